dmem_responder: RTL and testbench

//  Data-memory responder for the core's dmem port. It serves 64-bit

---
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-side dmem request/response bundle
interface dmem_responder_if;
  logic        ren;
  logic        wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        stall;
  logic        fault;

  // Core side: drives requests, observes load data and flow/fault status.
  modport master (
    output ren,
    output wen,
    output addr,
    output wdata,
    input  rdata,
    input  stall,
    input  fault
  );

  // Responder side.
  modport slave (
    input  ren,
    input  wen,
    input  addr,
    input  wdata,
    output rdata,
    output stall,
    output fault
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder with forwarding write buffer
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WB_DEPTH    = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  dmem_responder_if.slave             io_dmem,
  output logic                        o_fault_sticky,
  output logic [$clog2(WB_DEPTH):0]   o_wb_count,
  output logic                        o_wb_empty
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  // Backing word array (not reset) and write-buffer storage.
  logic [63:0]   r_mem     [DEPTH_WORDS];
  logic [AW-1:0] r_wb_idx  [WB_DEPTH];
  logic [63:0]   r_wb_data [WB_DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_fault_sticky;

  logic [AW-1:0] w_idx;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_fault;
  logic          w_full;
  logic          w_store_ok;
  logic          w_stall;
  logic          w_enq;
  logic          w_port_free;
  logic          w_drain;
  logic          w_fwd_hit;
  logic [63:0]   w_fwd_data;
  logic [PW-1:0] w_pos;
  logic [63:0]   w_rdata;

  // Address decode. Since DEPTH_WORDS is a power of two, "addr >= DEPTH_WORDS*8"
  // is exactly "any bit above the word index is set".
  assign w_idx          = io_dmem.addr[AW+2:3];
  assign w_misaligned   = (io_dmem.addr[2:0] != 3'b000);
  assign w_out_of_range = (io_dmem.addr[63:AW+3] != '0);

  // Fault is forced low while reset is held so the core sees a quiet port.
  assign w_fault = i_rst_n & (io_dmem.ren | io_dmem.wen) &
                   (w_misaligned | w_out_of_range | (io_dmem.ren & io_dmem.wen));

  assign w_full     = (r_count == CW'(WB_DEPTH));
  assign w_store_ok = i_rst_n & io_dmem.wen & ~w_fault;
  assign w_stall    = w_store_ok & w_full;
  assign w_enq      = w_store_ok & ~w_full;

  // The array port is busy for loads and for accepted stores; a stalled store
  // leaves it free, which is what lets a full buffer make room for the retry.
  assign w_port_free = ~io_dmem.ren & (~io_dmem.wen | w_stall);
  assign w_drain     = (r_count != '0) & w_port_free;

  // Forwarding scan from oldest to youngest valid entry; a later match
  // overrides an earlier one, so the youngest matching store wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_pos      = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_pos = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_wb_idx[w_pos] == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb_data[w_pos];
      end
    end
  end

  // Load data: forwarded entry, else array word; zero on fault, idle or reset.
  always_comb begin
    w_rdata = '0;
    if (i_rst_n && io_dmem.ren && !w_fault) begin
      if (w_fwd_hit) begin
        w_rdata = w_fwd_data;
      end else begin
        w_rdata = r_mem[w_idx];
      end
    end
  end

  // Buffer pointers and occupancy; enqueue and drain are mutually exclusive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_enq) begin
      r_tail  <= r_tail + 1'b1;
      r_count <= r_count + 1'b1;
    end else if (w_drain) begin
      r_head  <= r_head + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  // Entry payload capture at the tail; stale slots are masked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_wb_idx[r_tail]  <= w_idx;
      r_wb_data[r_tail] <= io_dmem.wdata;
    end
  end

  // Retire the oldest buffered store into the array on a free port cycle.
  always_ff @(posedge i_clk) begin
    if (w_drain) begin
      r_mem[r_wb_idx[r_head]] <= r_wb_data[r_head];
    end
  end

  // Sticky fault flag, only cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault_sticky <= 1'b0;
    end else if (w_fault) begin
      r_fault_sticky <= 1'b1;
    end
  end

  assign io_dmem.rdata = w_rdata;
  assign io_dmem.stall = w_stall;
  assign io_dmem.fault = w_fault;
  assign o_fault_sticky = r_fault_sticky;
  assign o_wb_count     = r_count;
  assign o_wb_empty     = (r_count == '0);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic       i_clk;
  logic       i_rst_n;
  logic       o_fault_sticky;
  logic [2:0] o_wb_count;
  logic       o_wb_empty;
  int         n_tests;
  int         n_fail;

  dmem_responder_if u_if ();

  dmem_responder #(.DEPTH_WORDS(1024), .WB_DEPTH(4)) u_dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .io_dmem        (u_if),
    .o_fault_sticky (o_fault_sticky),
    .o_wb_count     (o_wb_count),
    .o_wb_empty     (o_wb_empty)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
    u_if.ren   = r;
    u_if.wen   = w;
    u_if.addr  = a;
    u_if.wdata = d;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    set_in(1'b1, 1'b0, 64'h44, 64'h0);
    #12;
    n_tests++; if (u_if.rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", u_if.rdata); end
    n_tests++; if (u_if.fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", u_if.fault); end
    n_tests++; if (u_if.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", u_if.stall); end
    n_tests++; if (o_wb_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", o_wb_count); end
    n_tests++; if (o_wb_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", o_wb_empty); end
    n_tests++; if (o_fault_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %b want 0", o_fault_sticky); end
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_fwd();
    set_in(1'b0, 1'b1, 64'h40, 64'h1122334455667788);
    #1;
    n_tests++; if (u_if.stall !== 1'b0) begin n_fail++; $display("FAIL t1_stall: got %b want 0", u_if.stall); end
    tick();
    n_tests++; if (o_wb_count !== 3'd1) begin n_fail++; $display("FAIL t1_count1: got %0d want 1", o_wb_count); end
    set_in(1'b1, 1'b0, 64'h40, 64'h0);
    #1;
    n_tests++; if (u_if.rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL t1_fwd: got %h want 1122334455667788", u_if.rdata); end
    tick();
    n_tests++; if (o_wb_count !== 3'd1) begin n_fail++; $display("FAIL t1_ld_blocks: got %0d want 1", o_wb_count); end
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    n_tests++; if (o_wb_count !== 3'd0) begin n_fail++; $display("FAIL t1_drained: got %0d want 0", o_wb_count); end
    set_in(1'b1, 1'b0, 64'h40, 64'h0);
    #1;
    n_tests++; if (u_if.rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL t1_array: got %h want 1122334455667788", u_if.rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(1'b0, 1'b1, 64'h80, 64'hA);
    tick();
    set_in(1'b0, 1'b1, 64'h80, 64'hB);
    tick();
    n_tests++; if (o_wb_count !== 3'd2) begin n_fail++; $display("FAIL t2_count2: got %0d want 2", o_wb_count); end
    set_in(1'b1, 1'b0, 64'h80, 64'h0);
    #1;
    n_tests++; if (u_if.rdata !== 64'hB) begin n_fail++; $display("FAIL t2_youngest: got %h want b", u_if.rdata); end
    tick();
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    tick();
    n_tests++; if (o_wb_count !== 3'd0) begin n_fail++; $display("FAIL t2_drained: got %0d want 0", o_wb_count); end
    set_in(1'b1, 1'b0, 64'h80, 64'h0);
    #1;
    n_tests++; if (u_if.rdata !== 64'hB) begin n_fail++; $display("FAIL t2_array: got %h want b", u_if.rdata); end
    tick();
  endtask

  task automatic test_full_stall();
    logic [63:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 64'hC0DE_0000_0000_0000 + 64'(i);
      set_in(1'b0, 1'b1, 64'(i * 8), v);
      #1;
      n_tests++; if (u_if.stall !== 1'b0) begin n_fail++; $display("FAIL t3_nostall%0d: got %b want 0", i, u_if.stall); end
      tick();
      n_tests++; if (o_wb_count !== 3'(i + 1)) begin n_fail++; $display("FAIL t3_fill%0d: got %0d want %0d", i, o_wb_count, i + 1); end
    end
    set_in(1'b0, 1'b1, 64'h20, 64'hC0DE_0000_0000_0004);
    #1;
    n_tests++; if (u_if.stall !== 1'b1) begin n_fail++; $display("FAIL t3_stall: got %b want 1", u_if.stall); end
    n_tests++; if (u_if.fault !== 1'b0) begin n_fail++; $display("FAIL t3_nofault: got %b want 0", u_if.fault); end
    tick();
    n_tests++; if (o_wb_count !== 3'd3) begin n_fail++; $display("FAIL t3_stall_drain: got %0d want 3", o_wb_count); end
    #1;
    n_tests++; if (u_if.stall !== 1'b0) begin n_fail++; $display("FAIL t3_retry_stall: got %b want 0", u_if.stall); end
    tick();
    n_tests++; if (o_wb_count !== 3'd4) begin n_fail++; $display("FAIL t3_retry: got %0d want 4", o_wb_count); end
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (o_wb_empty !== 1'b1) begin n_fail++; $display("FAIL t3_empty: got %b want 1", o_wb_empty); end
    for (int i = 0; i < 5; i++) begin
      v = 64'hC0DE_0000_0000_0000 + 64'(i);
      set_in(1'b1, 1'b0, 64'(i * 8), 64'h0);
      #1;
      n_tests++; if (u_if.rdata !== v) begin n_fail++; $display("FAIL t3_rb%0d: got %h want %h", i, u_if.rdata, v); end
      tick();
    end
  endtask

  task automatic test_fault();
    set_in(1'b1, 1'b0, 64'h44, 64'h0);
    #1;
    n_tests++; if (u_if.fault !== 1'b1) begin n_fail++; $display("FAIL t4_misalign: got %b want 1", u_if.fault); end
    n_tests++; if (u_if.rdata !== 64'h0) begin n_fail++; $display("FAIL t4_rdata0: got %h want 0", u_if.rdata); end
    n_tests++; if (o_fault_sticky !== 1'b0) begin n_fail++; $display("FAIL t4_sticky_pre: got %b want 0", o_fault_sticky); end
    tick();
    n_tests++; if (o_fault_sticky !== 1'b1) begin n_fail++; $display("FAIL t4_sticky: got %b want 1", o_fault_sticky); end
    set_in(1'b1, 1'b0, 64'h1FF8, 64'h0);
    #1;
    n_tests++; if (u_if.fault !== 1'b0) begin n_fail++; $display("FAIL t4_last_word: got %b want 0", u_if.fault); end
    tick();
    set_in(1'b0, 1'b1, 64'h2000, 64'h55);
    #1;
    n_tests++; if (u_if.fault !== 1'b1) begin n_fail++; $display("FAIL t4_oob: got %b want 1", u_if.fault); end
    n_tests++; if (u_if.stall !== 1'b0) begin n_fail++; $display("FAIL t4_oob_stall: got %b want 0", u_if.stall); end
    tick();
    n_tests++; if (o_wb_count !== 3'd0) begin n_fail++; $display("FAIL t4_oob_count: got %0d want 0", o_wb_count); end
    set_in(1'b1, 1'b1, 64'h0, 64'h77);
    #1;
    n_tests++; if (u_if.fault !== 1'b1) begin n_fail++; $display("FAIL t4_rw: got %b want 1", u_if.fault); end
    n_tests++; if (u_if.rdata !== 64'h0) begin n_fail++; $display("FAIL t4_rw_rdata: got %h want 0", u_if.rdata); end
    tick();
    n_tests++; if (o_wb_count !== 3'd0) begin n_fail++; $display("FAIL t4_rw_count: got %0d want 0", o_wb_count); end
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 64'h100 + 64'(i * 8), 64'hAAAA_0000 + 64'(i));
      tick();
    end
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 64'h100 + 64'(i * 8), 64'hBBBB_0000 + 64'(i));
      tick();
    end
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    n_tests++; if (o_wb_count !== 3'd3) begin n_fail++; $display("FAIL t5_pre_count: got %0d want 3", o_wb_count); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_tests++; if (o_wb_count !== 3'd0) begin n_fail++; $display("FAIL t5_count: got %0d want 0", o_wb_count); end
    n_tests++; if (o_wb_empty !== 1'b1) begin n_fail++; $display("FAIL t5_empty: got %b want 1", o_wb_empty); end
    n_tests++; if (o_fault_sticky !== 1'b0) begin n_fail++; $display("FAIL t5_sticky: got %b want 0", o_fault_sticky); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 64'h100 + 64'(i * 8), 64'h0);
      #1;
      n_tests++; if (u_if.rdata !== 64'hAAAA_0000 + 64'(i)) begin n_fail++; $display("FAIL t5_old%0d: got %h want %h", i, u_if.rdata, 64'hAAAA_0000 + 64'(i)); end
      tick();
    end
  endtask

  task automatic test_load_hold();
    logic [63:0] a;
    logic [63:0] e;
    set_in(1'b0, 1'b1, 64'h200, 64'hDEAD_0001);
    tick();
    set_in(1'b0, 1'b1, 64'h208, 64'hDEAD_0002);
    tick();
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       begin a = 64'h200; e = 64'hDEAD_0001; end
        1:       begin a = 64'h208; e = 64'hDEAD_0002; end
        default: begin a = 64'h40;  e = 64'h1122334455667788; end
      endcase
      set_in(1'b1, 1'b0, a, 64'h0);
      #1;
      n_tests++; if (u_if.rdata !== e) begin n_fail++; $display("FAIL t6_ld%0d: got %h want %h", i, u_if.rdata, e); end
      tick();
      n_tests++; if (o_wb_count !== 3'd2) begin n_fail++; $display("FAIL t6_hold%0d: got %0d want 2", i, o_wb_count); end
    end
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    n_tests++; if (o_wb_count !== 3'd1) begin n_fail++; $display("FAIL t6_idle1: got %0d want 1", o_wb_count); end
    tick();
    n_tests++; if (o_wb_count !== 3'd0) begin n_fail++; $display("FAIL t6_idle2: got %0d want 0", o_wb_count); end
    set_in(1'b1, 1'b0, 64'h208, 64'h0);
    #1;
    n_tests++; if (u_if.rdata !== 64'hDEAD_0002) begin n_fail++; $display("FAIL t6_array: got %h want dead0002", u_if.rdata); end
    tick();
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst_n = 1'b0;
    set_in(1'b0, 1'b0, 64'h0, 64'h0);
    test_reset();
    test_store_fwd();
    test_back_to_back();
    test_full_stall();
    test_fault();
    test_reset_mid();
    test_load_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
